// File: rtl/md_cell_pkg.sv
// Shared types and constants for the molecular-dynamics cell memories.
// Velocity records are packed {vz, vy, vx}, one VEL_COMP_WIDTH word per axis.
package md_cell_pkg;

    localparam int VEL_COMP_WIDTH = 32;
    localparam int VEL_DATA_WIDTH = 3 * VEL_COMP_WIDTH;

    localparam int VX_LSB = 0;
    localparam int VX_MSB = VX_LSB + VEL_COMP_WIDTH - 1;
    localparam int VY_LSB = VEL_COMP_WIDTH;
    localparam int VY_MSB = VY_LSB + VEL_COMP_WIDTH - 1;
    localparam int VZ_LSB = 2 * VEL_COMP_WIDTH;
    localparam int VZ_MSB = VZ_LSB + VEL_COMP_WIDTH - 1;

    typedef struct packed {
        logic [VEL_COMP_WIDTH-1:0] vz;
        logic [VEL_COMP_WIDTH-1:0] vy;
        logic [VEL_COMP_WIDTH-1:0] vx;
    } vel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SWAP = 2'd1,
        WAIT = 2'd2
    } swap_state_t;

    // Sideband carried alongside a read while the RAM access is in flight.
    typedef struct packed {
        logic vld;
        logic bank;
        logic oor;
    } rd_meta_t;

endpackage

// File: rtl/cell_bank_ram.sv
// Simple dual-port RAM for one velocity bank: one write port, one registered read port.
// Latency: read data appears one cycle after rd_en; write lands on the same edge.
// Backpressure: none; both ports accept every cycle, rd_data holds when rd_en is low.
module cell_bank_ram #(
    parameter int DATA_WIDTH = 96,
    parameter int DEPTH      = 220,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally never reset; callers guard addresses to < DEPTH.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/velocity_cell_pingpong.sv
// Double-buffered velocity memory: reads hit rd_bank, writes hit the shadow bank, swap exchanges them.
// Latency: read 1+OUT_REG cycles, fully pipelined; swap_ack one cycle after swap_req seen in IDLE.
// Backpressure: none; rd_en/wr_en always accepted, swap_req is a level held until swap_ack.
module velocity_cell_pingpong
    import md_cell_pkg::*;
#(
    parameter int DATA_WIDTH   = VEL_DATA_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int OUT_REG      = 1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  rd_bank,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

    logic                  rd_oor;
    logic                  wr_oor;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [1:0]            bank_re;
    logic [1:0]            bank_we;
    logic [DATA_WIDTH-1:0] bank_q [2];
    logic [ADDR_WIDTH-1:0] cnt_q [2];
    swap_state_t           state_q;
    swap_state_t           state_d;
    logic                  bank_flip;
    rd_meta_t              s1_q;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  addr_err_q;

    assign rd_oor = ({1'b0, rd_addr} >= ADDR_LIMIT);
    assign wr_oor = ({1'b0, wr_addr} >= ADDR_LIMIT);
    assign rd_ok  = rd_en & ~rd_oor;
    assign wr_ok  = wr_en & ~wr_oor;

    // Reads only touch the read bank and writes only the shadow bank, so the ports never collide.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_re[b] = rd_ok & (rd_bank == 1'(b));
        assign bank_we[b] = wr_ok & (rd_bank != 1'(b));

        cell_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (PARTICLE_NUM),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clock   (clock),
            .wr_en   (bank_we[b]),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (bank_re[b]),
            .rd_addr (rd_addr),
            .rd_data (bank_q[b])
        );
    end

    // Word 0 of a bank doubles as its particle count; mirror it in a register for immediate use.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else if (wr_ok && (wr_addr == '0)) begin
            cnt_q[~rd_bank] <= wr_data[ADDR_WIDTH-1:0];
        end
    end

    assign particle_count = cnt_q[rd_bank];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_bank <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_bank <= rd_bank ^ bank_flip;
        end
    end

    // The bank flips on entry to SWAP so the new bank and the ack appear in the same cycle.
    always_comb begin
        state_d   = state_q;
        bank_flip = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d   = SWAP;
                    bank_flip = 1'b1;
                end
            end
            SWAP: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!swap_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign swap_ack = (state_q == SWAP);

    // The bank is captured at issue so a swap landing mid-flight does not redirect the read.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q.vld  <= rd_en;
            s1_q.bank <= rd_bank;
            s1_q.oor  <= rd_oor;
        end
    end

    assign s1_data = (s1_q.vld && !s1_q.oor) ? bank_q[s1_q.bank] : '0;

    if (OUT_REG != 0) begin : g_out_reg
        logic                  out_vld_q;
        logic [DATA_WIDTH-1:0] out_dat_q;

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                out_vld_q <= 1'b0;
                out_dat_q <= '0;
            end else begin
                out_vld_q <= s1_q.vld;
                out_dat_q <= s1_data;
            end
        end

        assign rd_valid = out_vld_q;
        assign rd_data  = out_dat_q;
    end else begin : g_no_out_reg
        assign rd_valid = s1_q.vld;
        assign rd_data  = s1_data;
    end

    // A read and a write error in the same cycle merge into one pulse.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= (rd_en & rd_oor) | (wr_en & wr_oor);
        end
    end

    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// Directed bench for velocity_cell_pingpong; OUT_REG=1 and OUT_REG=0 instances share all inputs.
module tb_velocity_cell_pingpong;
    import md_cell_pkg::*;

    localparam int DW = VEL_DATA_WIDTH;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clock;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;

    logic          rd_valid,  rd_valid0;
    logic [DW-1:0] rd_data,   rd_data0;
    logic          swap_ack,  swap_ack0;
    logic          rd_bank,   rd_bank0;
    logic [AW-1:0] particle_count, particle_count0;
    logic          addr_err,  addr_err0;

    int n_total;
    int n_pass;

    velocity_cell_pingpong #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .OUT_REG(1)) dut (
        .clock(clock), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .rd_bank(rd_bank),
        .particle_count(particle_count), .addr_err(addr_err)
    );

    velocity_cell_pingpong #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .OUT_REG(0)) dut0 (
        .clock(clock), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid0),
        .rd_data(rd_data0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack0), .rd_bank(rd_bank0),
        .particle_count(particle_count0), .addr_err(addr_err0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mk(input int m);
        vel_t v;
        v.vz = 32'(m * 32'h3000);
        v.vy = 32'(m * 32'h200);
        v.vx = 32'(m * 32'h10);
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else n_pass++;
        n_total++; if (rd_data !== '0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
        n_total++; if (rd_data0 !== '0) $display("FAIL reset_rd_data0 got %h want 0", rd_data0); else n_pass++;
        n_total++; if (swap_ack !== 1'b0) $display("FAIL reset_swap_ack got %b want 0", swap_ack); else n_pass++;
        n_total++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err got %b want 0", addr_err); else n_pass++;
        n_total++; if (rd_bank !== 1'b0) $display("FAIL reset_rd_bank got %b want 0", rd_bank); else n_pass++;
        n_total++; if (particle_count !== 8'd0) $display("FAIL reset_count got %0d want 0", particle_count); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = mk(3);
        exp_d[1] = mk(2);
        exp_d[2] = mk(1);
        do_write(8'd0, DW'(3));
        do_write(8'd1, mk(3));
        do_write(8'd2, mk(2));
        do_write(8'd3, mk(1));
        swap_req = 1'b1;
        tick();
        n_total++; if (swap_ack !== 1'b1) $display("FAIL basic_ack got %b want 1", swap_ack); else n_pass++;
        n_total++; if (rd_bank !== 1'b1) $display("FAIL basic_rd_bank got %b want 1", rd_bank); else n_pass++;
        n_total++; if (particle_count !== 8'd3) $display("FAIL basic_count got %0d want 3", particle_count); else n_pass++;
        swap_req = 1'b0;
        tick();
        n_total++; if (swap_ack !== 1'b0) $display("FAIL basic_ack_pulse got %b want 0", swap_ack); else n_pass++;
        tick();
        for (int i = 0; i < 5; i++) begin
            rd_en   = (i < 3);
            rd_addr = AW'(i + 1);
            tick();
            n_total++;
            if (rd_valid0 !== (i < 3)) $display("FAIL basic_vld0[%0d] got %b want %b", i, rd_valid0, (i < 3));
            else if (i < 3 && rd_data0 !== exp_d[i]) $display("FAIL basic_dat0[%0d] got %h want %h", i, rd_data0, exp_d[i]);
            else n_pass++;
            n_total++;
            if (rd_valid !== (i >= 1 && i <= 3)) $display("FAIL basic_vld[%0d] got %b want %b", i, rd_valid, (i >= 1 && i <= 3));
            else if (i >= 1 && i <= 3 && rd_data !== exp_d[i-1]) $display("FAIL basic_dat[%0d] got %h want %h", i, rd_data, exp_d[i-1]);
            else n_pass++;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_swap_boundary();
        do_write(8'd0, DW'(7));
        do_write(8'd2, mk(5));
        swap_req = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 8'd2;
        tick();
        swap_req = 1'b0;
        rd_en    = 1'b0;
        n_total++; if (swap_ack !== 1'b1) $display("FAIL bnd_ack got %b want 1", swap_ack); else n_pass++;
        n_total++; if (rd_bank !== 1'b0) $display("FAIL bnd_rd_bank got %b want 0", rd_bank); else n_pass++;
        n_total++; if (particle_count !== 8'd7) $display("FAIL bnd_count got %0d want 7", particle_count); else n_pass++;
        n_total++; if (rd_data0 !== mk(2)) $display("FAIL bnd_old0 got %h want %h", rd_data0, mk(2)); else n_pass++;
        tick();
        n_total++; if (rd_valid !== 1'b1 || rd_data !== mk(2)) $display("FAIL bnd_old got %b/%h want 1/%h", rd_valid, rd_data, mk(2)); else n_pass++;
        rd_en   = 1'b1;
        rd_addr = 8'd2;
        tick();
        rd_en = 1'b0;
        n_total++; if (rd_valid0 !== 1'b1 || rd_data0 !== mk(5)) $display("FAIL bnd_new0 got %b/%h want 1/%h", rd_valid0, rd_data0, mk(5)); else n_pass++;
        tick();
        n_total++; if (rd_valid !== 1'b1 || rd_data !== mk(5)) $display("FAIL bnd_new got %b/%h want 1/%h", rd_valid, rd_data, mk(5)); else n_pass++;
        tick();
    endtask

    task automatic test_long_swap();
        int acks;
        acks     = 0;
        swap_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (swap_ack === 1'b1) acks++;
        end
        swap_req = 1'b0;
        tick();
        tick();
        n_total++; if (acks != 1) $display("FAIL long_ack_count got %0d want 1", acks); else n_pass++;
        n_total++; if (rd_bank !== 1'b1) $display("FAIL long_rd_bank got %b want 1", rd_bank); else n_pass++;
        n_total++; if (particle_count !== 8'd3) $display("FAIL long_count got %0d want 3", particle_count); else n_pass++;
    endtask

    task automatic test_write_with_swap();
        logic [DW-1:0] a5;
        a5       = {12{8'hA5}};
        wr_en    = 1'b1;
        wr_addr  = 8'd5;
        wr_data  = a5;
        swap_req = 1'b1;
        tick();
        wr_en    = 1'b0;
        swap_req = 1'b0;
        n_total++; if (rd_bank !== 1'b0) $display("FAIL wsw_rd_bank got %b want 0", rd_bank); else n_pass++;
        tick();
        tick();
        rd_en   = 1'b1;
        rd_addr = 8'd5;
        tick();
        rd_en = 1'b0;
        n_total++; if (rd_valid0 !== 1'b1 || rd_data0 !== a5) $display("FAIL wsw_data0 got %b/%h want 1/%h", rd_valid0, rd_data0, a5); else n_pass++;
        tick();
        n_total++; if (rd_valid !== 1'b1 || rd_data !== a5) $display("FAIL wsw_data got %b/%h want 1/%h", rd_valid, rd_data, a5); else n_pass++;
    endtask

    task automatic test_addr_err();
        rd_en   = 1'b1;
        rd_addr = 8'(PN);
        wr_en   = 1'b1;
        wr_addr = 8'd255;
        wr_data = '1;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        n_total++; if (addr_err !== 1'b1) $display("FAIL err_pulse got %b want 1", addr_err); else n_pass++;
        n_total++; if (addr_err0 !== 1'b1) $display("FAIL err_pulse0 got %b want 1", addr_err0); else n_pass++;
        n_total++; if (rd_valid0 !== 1'b1 || rd_data0 !== '0) $display("FAIL err_rd0 got %b/%h want 1/0", rd_valid0, rd_data0); else n_pass++;
        tick();
        n_total++; if (addr_err !== 1'b0) $display("FAIL err_single got %b want 0", addr_err); else n_pass++;
        n_total++; if (rd_valid !== 1'b1 || rd_data !== '0) $display("FAIL err_rd got %b/%h want 1/0", rd_valid, rd_data); else n_pass++;
        n_total++; if (particle_count !== 8'd7) $display("FAIL err_count got %0d want 7", particle_count); else n_pass++;
        rd_en   = 1'b1;
        rd_addr = 8'd5;
        tick();
        rd_en = 1'b0;
        tick();
        n_total++; if (rd_data !== {12{8'hA5}}) $display("FAIL err_ram got %h want %h", rd_data, {12{8'hA5}}); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        tick();
        n_total++; if (rd_bank !== 1'b1) $display("FAIL rst_pre_bank got %b want 1", rd_bank); else n_pass++;
        rd_en   = 1'b1;
        rd_addr = 8'd1;
        tick();
        rd_addr = 8'd2;
        tick();
        n_total++; if (rd_valid !== 1'b1 || rd_valid0 !== 1'b1) $display("FAIL rst_pre_vld got %b/%b want 1/1", rd_valid, rd_valid0); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL rst_drop_vld got %b want 0", rd_valid); else n_pass++;
        n_total++; if (rd_valid0 !== 1'b0) $display("FAIL rst_drop_vld0 got %b want 0", rd_valid0); else n_pass++;
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if (rd_bank !== 1'b0 || rd_bank0 !== 1'b0) $display("FAIL rst_bank got %b/%b want 0/0", rd_bank, rd_bank0); else n_pass++;
        n_total++; if (particle_count !== 8'd0 || particle_count0 !== 8'd0) $display("FAIL rst_count got %0d/%0d want 0/0", particle_count, particle_count0); else n_pass++;
        n_total++; if (rd_valid !== 1'b0 || rd_valid0 !== 1'b0) $display("FAIL rst_vld_after got %b/%b want 0/0", rd_valid, rd_valid0); else n_pass++;
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        swap_req = 1'b0;
        test_reset();
        test_basic();
        test_swap_boundary();
        test_long_swap();
        test_write_with_swap();
        test_addr_err();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
